// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM states, segment bit order
// and the active-high hex-to-segment table.
package seven_seg_scan_driver_pkg;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_ON    = 1'b1
   } state_t;

   // Segment bit positions within the 7-bit {g,f,e,d,c,b,a} bus
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seven_seg_scan_driver_hex_to_seven_seg.sv
// Combinational nibble to active-high segment decode; zero latency, no flow control.
module hex_to_seven_seg
   import seven_seg_scan_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed hex display scanner with blank gap between digits; pins registered (1 cycle),
// loads always accepted and applied at frame wrap. SEVEN_SEG_LZ_BLANK_EN enables leading-zero blanking.
module seven_seg_scan_driver
   import seven_seg_scan_driver_pkg::*;
#(
   parameter int NUM_DIGITS     = 2,
   parameter int ON_CYCLES      = 25000,
   parameter int BLANK_CYCLES   = 250,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   input  logic [4*NUM_DIGITS-1:0] i_Value,
   input  logic                    i_Load,
   output logic [6:0]              o_Segment,
   output logic [NUM_DIGITS-1:0]   o_Digit_En,
   output logic                    o_Frame_Done
);

   localparam int MAX_LIMIT = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int CNT_W     = $clog2(MAX_LIMIT + 1);
   localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic [IDX_W-1:0]          idx, idx_nxt;
   logic                      wrap;
   logic [4*NUM_DIGITS-1:0]   display, shadow;
   logic                      pending;
   logic [3:0]                nibble;
   logic [6:0]                seg_dec;
   logic [6:0]                seg_act;
   logic [NUM_DIGITS-1:0]     en_onehot;
   logic                      lz_blank;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = idx;
      wrap      = 1'b0;
      case (state)
         S_BLANK: begin
            if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
               state_nxt = S_ON;
               cnt_nxt   = '0;
            end
         end
         S_ON: begin
            if (cnt == CNT_W'(ON_CYCLES - 1)) begin
               state_nxt = S_BLANK;
               cnt_nxt   = '0;
               if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                  idx_nxt = '0;
                  wrap    = 1'b1;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_BLANK;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign nibble    = display[idx*4 +: 4];
   assign en_onehot = NUM_DIGITS'(1) << idx;

   hex_to_seven_seg u_hex (
      .nibble (nibble),
      .seg    (seg_dec)
   );

`ifdef SEVEN_SEG_LZ_BLANK_EN
   // Blank this digit when it and every more-significant nibble are zero; digit 0 always shows
   always_comb begin
      lz_blank = (idx != '0);
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (j >= int'(idx) && display[j*4 +: 4] != 4'h0)
            lz_blank = 1'b0;
      end
   end
`else
   assign lz_blank = 1'b0;
`endif

   assign seg_act = (state == S_ON && !lz_blank) ? seg_dec : 7'h00;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state        <= S_BLANK;
         cnt          <= '0;
         idx          <= '0;
         display      <= '0;
         shadow       <= '0;
         pending      <= 1'b0;
         o_Segment    <= SEG_OFF;
         o_Digit_En   <= DIG_OFF;
         o_Frame_Done <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         o_Segment    <= seg_act ^ SEG_OFF;
         o_Digit_En   <= (state == S_ON) ? (en_onehot ^ DIG_OFF) : DIG_OFF;
         o_Frame_Done <= wrap;
         // Copy takes the pre-load shadow; a load on the wrap cycle stays pending
         if (wrap && pending)
            display <= shadow;
         if (i_Load) begin
            shadow  <= i_Value;
            pending <= 1'b1;
         end else if (wrap) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized scoreboard bench for seven_seg_scan_driver with a frame-level reference model.
module tb_seven_seg_scan_driver;

   localparam int ND    = 2;
   localparam int ON    = 4;
   localparam int BLANK = 1;
   localparam int SLOT  = BLANK + ON;
   localparam int P     = ND * SLOT;

   logic            i_Clk = 1'b0;
   logic            i_Rst = 1'b1;
   logic [4*ND-1:0] i_Value = '0;
   logic            i_Load = 1'b0;
   logic [6:0]      o_Segment;
   logic [ND-1:0]   o_Digit_En;
   logic            o_Frame_Done;

   seven_seg_scan_driver #(
      .NUM_DIGITS     (ND),
      .ON_CYCLES      (ON),
      .BLANK_CYCLES   (BLANK),
      .SEG_ACTIVE_LOW (1)
   ) dut (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_Value      (i_Value),
      .i_Load       (i_Load),
      .o_Segment    (o_Segment),
      .o_Digit_En   (o_Digit_En),
      .o_Frame_Done (o_Frame_Done)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct {
      logic [6:0]    seg;
      logic [ND-1:0] en;
      logic          fd;
   } exp_t;

   typedef struct {
      int            cyc;
      logic [4*ND-1:0] val;
   } load_t;

   logic [6:0] hex_tab [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   exp_t  exp_q[$];
   load_t load_log[$];
   int    kcyc = 0;
   int    checks = 0;
   int    errors = 0;

   // Value shown in frame f: latest load accepted at least two cycles before that frame starts
   function automatic logic [4*ND-1:0] frame_value(input int f);
      logic [4*ND-1:0] v;
      v = '0;
      foreach (load_log[i])
         if (load_log[i].cyc <= f * P - 2)
            v = load_log[i].val;
      return v;
   endfunction

   function automatic exp_t model(input int k);
      exp_t            e;
      int              p, slot, q;
      logic [4*ND-1:0] v;
      logic [3:0]      nib;
      logic            lit, blank_lz;
      p        = k % P;
      slot     = p / SLOT;
      q        = p % SLOT;
      lit      = (q >= BLANK);
      v        = frame_value(k / P);
      nib      = 4'((v >> (4 * slot)) & 'hF);
      blank_lz = 1'b0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
      blank_lz = (slot > 0) && ((v >> (4 * slot)) == 0);
`endif
      e.seg = ~((lit && !blank_lz) ? hex_tab[nib] : 7'h00);
      e.en  = lit ? ~(ND'(1) << slot) : {ND{1'b1}};
      e.fd  = (p == P - 1);
      return e;
   endfunction

   task automatic tick(input logic ld, input logic [4*ND-1:0] v, input logic rst);
      exp_t off;
      i_Load  = ld;
      i_Value = v;
      i_Rst   = rst;
      @(posedge i_Clk);
      if (rst) begin
         load_log.delete();
         kcyc    = 0;
         off.seg = 7'h7F;
         off.en  = {ND{1'b1}};
         off.fd  = 1'b0;
         exp_q.push_back(off);
      end else begin
         exp_q.push_back(model(kcyc));
         if (ld) load_log.push_back('{kcyc, v});
         kcyc++;
      end
      @(negedge i_Clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0);
   endtask

   task automatic wait_phase(input int ph);
      int guard;
      guard = 0;
      while (kcyc % P != ph && guard < 4 * P) begin
         tick(1'b0, '0, 1'b0);
         guard++;
      end
   endtask

   // Monitor: one registered output sample per cycle, compared against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge i_Clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (o_Digit_En !== e.en) begin
               errors++;
               $display("FAIL digit_en t=%0t got=%b want=%b", $time, o_Digit_En, e.en);
            end
            checks++;
            if (o_Segment !== e.seg) begin
               errors++;
               $display("FAIL segment t=%0t got=%h want=%h", $time, o_Segment, e.seg);
            end
            checks++;
            if (o_Frame_Done !== e.fd) begin
               errors++;
               $display("FAIL frame_done t=%0t got=%b want=%b", $time, o_Frame_Done, e.fd);
            end
            checks++;
            if ($countones(~o_Digit_En) > 1) begin
               errors++;
               $display("FAIL onehot_en t=%0t got=%b want=at_most_one_low", $time, o_Digit_En);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge i_Clk);
      tick(1'b0, '0, 1'b1);
      tick(1'b1, 8'h3C, 1'b1);
      tick(1'b0, '0, 1'b1);
      idle(25);

      // Mid-frame load: current frame unchanged, next frame shows A5
      wait_phase(3);
      tick(1'b1, 8'hA5, 1'b0);
      idle(2 * P);

      // Load on the wrap cycle lands one frame later
      wait_phase(P - 1);
      tick(1'b1, 8'h5E, 1'b0);
      idle(3 * P);

      // Reset during digit1 lit with a pending load: load is lost
      wait_phase(2);
      tick(1'b1, 8'hC3, 1'b0);
      wait_phase(SLOT + 2);
      tick(1'b0, '0, 1'b1);
      idle(2 * P);

      // Leading-zero cases
      wait_phase(4);
      tick(1'b1, 8'h07, 1'b0);
      idle(2 * P);
      wait_phase(4);
      tick(1'b1, 8'h00, 1'b0);
      idle(2 * P);

      // Back-to-back loads: last one wins
      wait_phase(5);
      tick(1'b1, 8'h12, 1'b0);
      tick(1'b1, 8'hF9, 1'b0);
      idle(2 * P);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(299) == 0)
            tick($urandom_range(1), 8'($urandom), 1'b1);
         else
            tick(($urandom_range(7) == 0), 8'($urandom), 1'b0);
      end
      idle(2);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got=%0d want=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
